wb_sram_slave: RTL and testbench

Wishbone B4 classic-cycle slave that fronts an on-chip word-organised SRAM; it is the responder paired with the CPU's Wishbone data/instruction masters in the SOPC. It decodes one 32-bit single-beat transfer at a time, inserts a programmable number of wait states, applies byte-lane selects on writes, and terminates each cycle with exactly one `wb_ack_o` or `wb_err_o` pulse. Big-endian byte lanes match the core: `sel[3]` ↔ `dat[31:24]` ↔ byte at `adr+0`.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_sram_array.sv | 33 +++
 rtl/wb_sram_slave.sv | 139 +++++++++++++
 tb/tb_wb_sram_slave.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone bus widths and slave FSM state encoding
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 32;
    localparam int WB_SEL_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_ERR  = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_sram_array.sv
// rtl/wb_sram_array.sv - word-organised synchronous RAM, per-byte write enable, registered read
//   clk   : clock
//   addr  : word address
//   we    : write strobe, qualified per lane by be
//   be    : byte-lane enables, be[3] <-> data[31:24]
//   wdata : write data
//   rdata : read data, registered every cycle from addr (old contents on a write)
module wb_sram_array
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [WB_SEL_W-1:0]   be,
    input  logic [WB_DATA_W-1:0]  wdata,
    output logic [WB_DATA_W-1:0]  rdata
);

    logic [WB_DATA_W-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // No reset on the array or the read register so the tools can infer block RAM.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WB_SEL_W; b++) begin
            if (we && be[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_sram_slave.sv
// rtl/wb_sram_slave.sv - Wishbone B4 classic single-beat slave in front of an on-chip SRAM
//   clk, rst            : clock, asynchronous active-high reset
//   wb_cyc_i, wb_stb_i  : request = cyc & stb, sampled in IDLE only
//   wb_we_i             : 1 = write, 0 = read
//   wb_adr_i            : byte address (word aligned, in range, else error)
//   wb_sel_i            : byte-lane enables for writes
//   wb_dat_i / wb_dat_o : write data / read data (zero unless acking)
//   wb_ack_o, wb_err_o  : one-cycle termination pulses
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_we_i,
    input  logic [WB_ADDR_W-1:0] wb_adr_i,
    input  logic [WB_SEL_W-1:0]  wb_sel_i,
    input  logic [WB_DATA_W-1:0] wb_dat_i,
    output logic [WB_DATA_W-1:0] wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o
);

    localparam bit         NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    wb_state_t state, next_state;

    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] adr_q;
    logic                  we_q;
    logic [WB_SEL_W-1:0]   sel_q;
    logic [WB_DATA_W-1:0]  dat_q;

    logic                  req;
    logic                  addr_err;
    logic                  enter_ack;
    logic                  in_idle;

    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [WB_SEL_W-1:0]   ram_be;
    logic [WB_DATA_W-1:0]  ram_wdata;
    logic [WB_DATA_W-1:0]  ram_rdata;

    assign req      = wb_cyc_i & wb_stb_i;
    assign in_idle  = (state == ST_IDLE);
    assign addr_err = (wb_adr_i[1:0] != 2'b00) ||
                      ((wb_adr_i >> (ADDR_WIDTH + 2)) != '0);

    // The RAM commits writes and registers read data on the edge entering ACK.
    // With zero wait states that edge is also the capture edge, so the RAM must
    // see the live bus then, and the captured copy from WAIT onwards.
    assign enter_ack = (in_idle && req && !addr_err && NO_WAIT) ||
                       ((state == ST_WAIT) && req && (wait_cnt == 4'd0));

    assign ram_addr  = in_idle ? wb_adr_i[ADDR_WIDTH+1:2] : adr_q;
    assign ram_be    = in_idle ? wb_sel_i : sel_q;
    assign ram_wdata = in_idle ? wb_dat_i : dat_q;
    assign ram_we    = enter_ack && (in_idle ? wb_we_i : we_q);

    wb_sram_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (ram_be),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (addr_err) begin
                        next_state = ST_ERR;
                    end else if (NO_WAIT) begin
                        next_state = ST_ACK;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    next_state = ST_IDLE;
                end else if (wait_cnt == 4'd0) begin
                    next_state = ST_ACK;
                end
            end
            ST_ACK:  next_state = ST_IDLE;
            ST_ERR:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        wb_ack_o = (state == ST_ACK);
        wb_err_o = (state == ST_ERR);
        wb_dat_o = (state == ST_ACK) ? ram_rdata : '0;
    end

    // Request capture and wait counter; bus changes during WAIT are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 4'd0;
            adr_q    <= '0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            dat_q    <= '0;
        end else begin
            if (in_idle && req && !addr_err) begin
                wait_cnt <= WAIT_LOAD;
                adr_q    <= wb_adr_i[ADDR_WIDTH+1:2];
                we_q     <= wb_we_i;
                sel_q    <= wb_sel_i;
                dat_q    <= wb_dat_i;
            end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// tb/tb_wb_sram_slave.sv - self-checking bench for wb_sram_slave (WAIT_STATES 0 and 1 instances)
module tb_wb_sram_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic [31:0] adr [2];
    logic [3:0]  sel [2];
    logic [31:0] wdat[2];
    logic [31:0] rdat[2];
    logic        ack [2];
    logic        err [2];

    int n_cmp = 0;
    int n_bad = 0;

    // reference memories, byte addressed by word index
    logic [31:0] model0 [int];
    logic [31:0] model1 [int];

    always #5 clk = ~clk;

    wb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_adr_i(adr[0]), .wb_sel_i(sel[0]), .wb_dat_i(wdat[0]), .wb_dat_o(rdat[0]),
        .wb_ack_o(ack[0]), .wb_err_o(err[0])
    );

    wb_sram_slave #(.ADDR_WIDTH(12), .WAIT_STATES(1)) dut1 (
        .clk(clk), .rst(rst), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_adr_i(adr[1]), .wb_sel_i(sel[1]), .wb_dat_i(wdat[1]), .wb_dat_o(rdat[1]),
        .wb_ack_o(ack[1]), .wb_err_o(err[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // termination rules: never ack+err together, never terminations in consecutive cycles
    bit prev_term [2] = '{1'b0, 1'b0};
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (ack[d] || err[d]) begin
                n_cmp++;
                if ((ack[d] && err[d]) || prev_term[d]) begin
                    n_bad++;
                    $display("FAIL term_rule dut%0d: ack=%0b err=%0b prev=%0b", d, ack[d], err[d], prev_term[d]);
                end
            end
            prev_term[d] = ack[d] || err[d];
        end
    end

    function automatic bit is_err_addr(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'h4000);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // One transfer; called just after a rising edge with the DUT idle.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] wd, output bit got_ack, output bit got_err,
                        output logic [31:0] got_dat, output int lat);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = wd;
        got_ack = 1'b0; got_err = 1'b0; got_dat = '0; lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (ack[d] || err[d]) begin
                got_ack = ack[d]; got_err = err[d]; got_dat = rdat[d];
                break;
            end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        if (!got_ack && !got_err) begin
            n_cmp++; n_bad++;
            $display("FAIL timeout dut%0d adr=0x%08h: no termination in 20 cycles", d, a);
        end
        @(posedge clk); #1;
        chk($sformatf("pulse_end dut%0d", d), {ack[d], err[d]}, 32'd0);
        chk($sformatf("dat_idle dut%0d", d), rdat[d], 32'd0);
    endtask

    // Modelled transfer: expectations computed from the address rules and byte merge.
    task automatic mxfer(input int d, input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] wd);
        bit ga, ge; logic [31:0] gd; int lat; bit e; int widx; logic [31:0] exp_d;
        e = is_err_addr(a);
        widx = int'(a / 4);
        xfer(d, w, a, s, wd, ga, ge, gd, lat);
        chk($sformatf("rnd_term dut%0d a=%08h", d, a), {ga, ge}, e ? 32'd1 : 32'd2);
        chk($sformatf("rnd_lat dut%0d", d), lat, e ? 32'd1 : 32'(d + 1));
        if (e) begin
            chk("rnd_errdat", gd, 32'd0);
        end else if (w) begin
            if (d == 0) model0[widx] = merge(model0.exists(widx) ? model0[widx] : 32'd0, wd, s);
            else        model1[widx] = merge(model1.exists(widx) ? model1[widx] : 32'd0, wd, s);
        end else begin
            exp_d = (d == 0) ? model0[widx] : model1[widx];
            chk($sformatf("rnd_rd dut%0d a=%08h", d, a), gd, exp_d);
        end
    endtask

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] wd;
        bit          exp_err;
        bit          chk_dat;
        logic [31:0] exp_dat;
    } vec_t;

    initial begin
        vec_t vt[$];
        bit ga, ge; logic [31:0] gd; int lat;
        int last_ack, cyc_no, acks;
        logic [31:0] exp_b2b [3];

        for (int d = 0; d < 2; d++) begin
            cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = 0; sel[d] = 0; wdat[d] = 0;
        end

        vt.push_back('{1'b1, 32'h10,   4'hF, 32'h11223344, 1'b0, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'h10,   4'hF, 32'h0,        1'b0, 1'b1, 32'h11223344});
        vt.push_back('{1'b1, 32'h10,   4'h4, 32'hAABBCCDD, 1'b0, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'h10,   4'h0, 32'h0,        1'b0, 1'b1, 32'h11BB3344});
        vt.push_back('{1'b0, 32'h4000, 4'hF, 32'h0,        1'b1, 1'b1, 32'h0});
        vt.push_back('{1'b0, 32'h12,   4'hF, 32'h0,        1'b1, 1'b1, 32'h0});
        vt.push_back('{1'b1, 32'h4010, 4'hF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0});
        vt.push_back('{1'b1, 32'h11,   4'hF, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h0});
        vt.push_back('{1'b1, 32'h10,   4'h0, 32'h99999999, 1'b0, 1'b0, 32'h0});
        vt.push_back('{1'b0, 32'h10,   4'hF, 32'h0,        1'b0, 1'b1, 32'h11BB3344});

        // reset state
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_ack dut%0d", d), ack[d], 1'b0);
            chk($sformatf("rst_err dut%0d", d), err[d], 1'b0);
            chk($sformatf("rst_dat dut%0d", d), rdat[d], 32'd0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // directed table on the one-wait-state instance
        foreach (vt[i]) begin
            xfer(1, vt[i].w, vt[i].a, vt[i].s, vt[i].wd, ga, ge, gd, lat);
            chk($sformatf("vec%0d_term", i), {ga, ge}, vt[i].exp_err ? 32'd1 : 32'd2);
            chk($sformatf("vec%0d_lat", i), lat, vt[i].exp_err ? 32'd1 : 32'd2);
            if (vt[i].chk_dat) chk($sformatf("vec%0d_dat", i), gd, vt[i].exp_dat);
        end
        model1[4] = 32'h11BB3344;

        // abort: drop strobe during WAIT of a write
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h10; sel[1] = 4'hF; wdat[1] = 32'h55667788;
        @(posedge clk); #1;
        stb[1] = 0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack[1] || err[1]) acks++;
        end
        cyc[1] = 0;
        chk("abort_noterm", acks, 32'd0);
        xfer(1, 1'b0, 32'h10, 4'hF, 32'h0, ga, ge, gd, lat);
        chk("abort_rd", gd, 32'h11BB3344);

        // reset during WAIT of a write
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h10; sel[1] = 4'hF; wdat[1] = 32'hDEADBEEF;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("rstmid_out", {rdat[1][29:0], ack[1], err[1]}, 32'd0);
        cyc[1] = 0; stb[1] = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (ack[1] || err[1]) acks++;
        end
        chk("rstmid_noterm", acks, 32'd0);
        xfer(1, 1'b0, 32'h10, 4'hF, 32'h0, ga, ge, gd, lat);
        chk("rstmid_rd", gd, 32'h11BB3344);
        chk("rstmid_lat", lat, 32'd2);

        // back-to-back reads with strobe held, zero wait states
        for (int k = 0; k < 3; k++) begin
            exp_b2b[k] = $urandom;
            xfer(0, 1'b1, 32'h20 + 32'(4 * k), 4'hF, exp_b2b[k], ga, ge, gd, lat);
            model0[8 + k] = exp_b2b[k];
        end
        cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h20; sel[0] = 4'h0;
        acks = 0; last_ack = 0; cyc_no = 0;
        while (acks < 3 && cyc_no < 20) begin
            @(posedge clk); #1;
            cyc_no++;
            if (ack[0]) begin
                chk($sformatf("b2b_dat%0d", acks), rdat[0], exp_b2b[acks]);
                chk($sformatf("b2b_gap%0d", acks), cyc_no - last_ack, (acks == 0) ? 32'd1 : 32'd2);
                last_ack = cyc_no;
                acks++;
                adr[0] = 32'h20 + 32'(4 * acks);
            end
        end
        cyc[0] = 0; stb[0] = 0;
        chk("b2b_count", acks, 32'd3);
        @(posedge clk); #1;

        // randomized traffic against the reference memories
        for (int d = 0; d < 2; d++) begin
            for (int wi = 0; wi < 64; wi++) mxfer(d, 1'b1, 32'(wi * 4), 4'hF, $urandom);
            for (int n = 0; n < 200; n++) begin
                logic [31:0] a;
                int kind;
                kind = $urandom_range(0, 7);
                a = 32'($urandom_range(0, 63)) * 4;
                if (kind == 0) a = a + 32'($urandom_range(1, 3));
                else if (kind == 1) a = a | (32'h1 << $urandom_range(14, 31));
                mxfer(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
